cacheline_burst_adaptor: RTL and testbench
==========================================

// Module: cacheline_burst_adaptor
// PURPOSE
//  Sits between the L1 cache and physical memory. Converts one 256-bit line read/write into
//  a sequence of 64-bit bursts: 4 beats per line, lowest beat first.
//  - Upstream side: cache pmem_* signals, line-wide, resp_o pulse on completion.
//  - Downstream side: memory burst port, beat-wide, resp_i qualifies each beat.
// PARAMETERS
//  LINE_WIDTH   256  line size in bits (cache data array width)
//  BURST_WIDTH  64   bits per memory beat; BEATS = LINE_WIDTH/BURST_WIDTH (integer, >=2)
//  ADDR_WIDTH   32   byte address width
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst        in   1           synchronous, active-high reset
//  address_i  in   ADDR_WIDTH  line address from cache; low log2(LINE_WIDTH/8) bits ignored
//  line_i     in   LINE_WIDTH  writeback data from cache
//  read_i     in   1           line read request; held by cache until resp_o
//  write_i    in   1           line write request; held by cache until resp_o
//  line_o     out  LINE_WIDTH  assembled read line; valid when resp_o=1 after a read
//  resp_o     out  1           one-cycle completion pulse for read or write
//  address_o  out  ADDR_WIDTH  line-aligned address to memory
//  burst_i    in   BURST_WIDTH read beat from memory; sampled when resp_i=1 in READ
//  burst_o    out  BURST_WIDTH write beat to memory
//  read_o     out  1           memory read request
//  write_o    out  1           memory write request
//  resp_i     in   1           memory beat strobe: one beat transferred per cycle it is high
// BEHAVIOUR
//  Reset: state=IDLE; beat counter=0; line_o, burst_o, address_o = 0; read_o, write_o, resp_o = 0.
//  FSM IDLE -> {READ | WRITE} -> DONE -> IDLE. Registered outputs, no combinational path in->out.
//  IDLE:
//   - On write_i=1: latch line_i and aligned address_i; go WRITE. write_i wins if read_i is also 1.
//   - Else on read_i=1: latch aligned address; go READ.
//   - resp_i is ignored.
//  READ:
//   - read_o=1 from the cycle after accept.
//   - Each cycle with resp_i=1: burst_i -> line_o beat[cnt] (bits cnt*BW +: BW); cnt++.
//   - Beats may be non-consecutive; idle cycles hold cnt.
//   - On the beat cnt=BEATS-1: deassert read_o next cycle; go DONE.
//  WRITE:
//   - write_o=1 and burst_o=line beat[cnt] from the cycle after accept.
//   - Each cycle with resp_i=1: that beat is consumed; burst_o advances to beat[cnt+1] next cycle.
//   - After the last beat: deassert write_o; go DONE.
//  DONE:
//   - resp_o=1 for exactly one cycle; read_o=write_o=0; cnt=0.
//   - read_i/write_i are ignored (the cache drops them this cycle).
//   - Go IDLE. A new request is accepted the following cycle at the earliest.
//  Latency:
//   - Request seen at cycle 0 -> read_o/write_o high at cycle 1.
//   - Last beat at cycle k -> resp_o at k+1.
//   - Back-to-back 4-beat best case: resp_o at cycle 5.
//  line_o holds the last completed read line until the next read beat overwrites it.
//  Writes never modify line_o.
//  address_o is stable for the whole transaction; low 5 bits always 0 (for default LINE_WIDTH).
//  Request change mid-transaction: dropping read_i/write_i is illegal. The adaptor completes
//  the latched transaction regardless.
//  rst mid-transaction: IDLE next cycle, read_o/write_o/resp_o drop, partial data discarded,
//  no resp_o issued. Memory-side recovery is the memory model's responsibility.
//  Counter width $clog2(BEATS). Wrap to 0 only via DONE, never by overflow.
// STRUCTURE
//  Shared package rv32i_types gains: LINE_WIDTH/BURST_WIDTH localparams (256/64) and
//  typedef logic [255:0] cacheline_t. The state enum {IDLE,READ,WRITE,DONE} stays local.
//  Single module; no sub-module. Shift-free: beat select by indexed part-select on cnt.
// TESTING
//  1. Read, resp_i high cycles 3-6 with beats 64'h0..0A,0B,0C,0D ->
//     resp_o @7 only, line_o=={0D,0C,0B,0A}, read_o low @7.
//  2. Write of line 256'h{DDDD..,CCCC..,BBBB..,AAAA..}, resp_i on cycles 2,4,5,9 ->
//     burst_o sequence AAAA,BBBB,CCCC,DDDD at those cycles; resp_o @10.
//  3. read_i=write_i=1 in IDLE, address_i=32'h1234_567F ->
//     write_o=1, read_o=0, address_o=32'h1234_5660.
//  4. rst asserted after 2 read beats -> next cycle read_o=0, resp_o never pulses;
//     next read of new data yields a fresh full line with no stale beats.
//  5. resp_i held high while IDLE and while resp_o=1 ->
//     no state change, no extra beats counted, line_o unchanged.
//  6. Back-to-back: cache re-asserts read_i the cycle after resp_o ->
//     accepted, second transaction completes with correct address_o/line_o.

Source files
------------

// File: rtl/cacheline_burst_adaptor_pkg.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor_pkg
// Shared sizing constants and types for the cache-line <-> memory-burst adaptor.
//   LINE_WIDTH  : cache line width in bits
//   BURST_WIDTH : memory beat width in bits
//   ADDR_WIDTH  : byte address width
//   BEATS       : beats per line, CNT_W : beat counter width
// align_addr() clears the byte-within-line offset of an address.
// -----------------------------------------------------------------------------
package cacheline_burst_adaptor_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int OFFSET_W    = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0]  cacheline_t;
  typedef logic [BURST_WIDTH-1:0] burst_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [CNT_W-1:0]       cnt_t;

  // Mask with every byte-offset bit of a line set.
  localparam addr_t OFFSET_MASK = addr_t'((64'd1 << OFFSET_W) - 64'd1);

  function automatic addr_t align_addr(input addr_t addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor_if
// Bundles the cache-side (line-wide) and memory-side (beat-wide) signals.
//   Cache side : address_i, line_i, read_i, write_i -> line_o, resp_o
//   Memory side: burst_i, resp_i -> address_o, burst_o, read_o, write_o
// Modports: slave = the adaptor's view, master = the environment's view.
// -----------------------------------------------------------------------------
interface cacheline_burst_adaptor_if;
  import cacheline_burst_adaptor_pkg::*;

  addr_t      address_i;
  cacheline_t line_i;
  logic       read_i;
  logic       write_i;
  cacheline_t line_o;
  logic       resp_o;
  addr_t      address_o;
  burst_t     burst_i;
  burst_t     burst_o;
  logic       read_o;
  logic       write_o;
  logic       resp_i;

  modport slave (
    input  address_i, line_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, address_o, burst_o, read_o, write_o
  );

  modport master (
    output address_i, line_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, burst_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor
// Turns one cache-line read/write into BEATS memory beats, lowest beat first,
// and pulses resp_o for one cycle once the line transfer is complete.
// Ports:
//   clk : clock, all state changes on posedge
//   rst : synchronous active-high reset
//   bus : cacheline_burst_adaptor_if.slave (cache side + memory side)
// Every output comes straight from a register; there is no input->output
// combinational path.
// -----------------------------------------------------------------------------
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adaptor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_r, state_next_s;
  cnt_t       cnt_r, cnt_next_s;
  cacheline_t wline_r, wline_next_s;
  cacheline_t line_r, line_next_s;
  addr_t      addr_r, addr_next_s;
  burst_t     burst_r, burst_next_s;
  logic       read_r, read_next_s;
  logic       write_r, write_next_s;
  logic       resp_r, resp_next_s;
  cnt_t       cnt_inc_s;
  logic       last_beat_s;

  assign cnt_inc_s   = cnt_r + cnt_t'(1'b1);
  assign last_beat_s = (cnt_r == cnt_t'(BEATS - 1));

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    wline_next_s = wline_r;
    line_next_s  = line_r;
    addr_next_s  = addr_r;
    burst_next_s = burst_r;
    read_next_s  = read_r;
    write_next_s = write_r;
    resp_next_s  = 1'b0;

    case (state_r)
      IDLE: begin
        // Write has priority when the cache raises both requests.
        if (bus.write_i) begin
          state_next_s = WRITE;
          wline_next_s = bus.line_i;
          addr_next_s  = align_addr(bus.address_i);
          burst_next_s = bus.line_i[BURST_WIDTH-1:0];
          cnt_next_s   = {CNT_W{1'b0}};
          write_next_s = 1'b1;
        end else if (bus.read_i) begin
          state_next_s = READ;
          addr_next_s  = align_addr(bus.address_i);
          cnt_next_s   = {CNT_W{1'b0}};
          read_next_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end

      READ: begin
        if (bus.resp_i) begin
          line_next_s[int'(cnt_r)*BURST_WIDTH +: BURST_WIDTH] = bus.burst_i;
          if (last_beat_s) begin
            state_next_s = DONE;
            cnt_next_s   = {CNT_W{1'b0}};
            read_next_s  = 1'b0;
            resp_next_s  = 1'b1;
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end else begin
          state_next_s = READ;
        end
      end

      WRITE: begin
        // burst_o already shows beat[cnt]; on acceptance preload beat[cnt+1].
        if (bus.resp_i) begin
          if (last_beat_s) begin
            state_next_s = DONE;
            cnt_next_s   = {CNT_W{1'b0}};
            write_next_s = 1'b0;
            resp_next_s  = 1'b1;
          end else begin
            cnt_next_s   = cnt_inc_s;
            burst_next_s = wline_r[int'(cnt_inc_s)*BURST_WIDTH +: BURST_WIDTH];
          end
        end else begin
          state_next_s = WRITE;
        end
      end

      DONE: begin
        // resp_o is high this cycle; requests are ignored until IDLE.
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
        read_next_s  = 1'b0;
        write_next_s = 1'b0;
      end

      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
        read_next_s  = 1'b0;
        write_next_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      wline_r <= {LINE_WIDTH{1'b0}};
      line_r  <= {LINE_WIDTH{1'b0}};
      addr_r  <= {ADDR_WIDTH{1'b0}};
      burst_r <= {BURST_WIDTH{1'b0}};
      read_r  <= 1'b0;
      write_r <= 1'b0;
      resp_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      wline_r <= wline_next_s;
      line_r  <= line_next_s;
      addr_r  <= addr_next_s;
      burst_r <= burst_next_s;
      read_r  <= read_next_s;
      write_r <= write_next_s;
      resp_r  <= resp_next_s;
    end
  end

  assign bus.line_o    = line_r;
  assign bus.resp_o    = resp_r;
  assign bus.address_o = addr_r;
  assign bus.burst_o   = burst_r;
  assign bus.read_o    = read_r;
  assign bus.write_o   = write_r;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_burst_adaptor
// Directed bench for cacheline_burst_adaptor. The bench plays both the cache
// and the memory. Expected completions and expected write beats are queued
// when a request is issued and popped when the adaptor produces them.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cacheline_burst_adaptor;
  import cacheline_burst_adaptor_pkg::*;

  logic clk;
  logic rst;

  cacheline_burst_adaptor_if bus();

  cacheline_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_read;
    addr_t      addr;
    cacheline_t line;
  } resp_exp_t;

  resp_exp_t  resp_q[$];
  burst_t     beat_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  cacheline_t last_line;

  task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs,
                       input logic [LINE_WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any completion pulse.
  task automatic cyc();
    resp_exp_t e;
    @(negedge clk);
    if (bus.resp_o === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp_o", bus.resp_o, 1'b0);
      end else begin
        e = resp_q.pop_front();
        check("resp_address_o", bus.address_o, e.addr);
        if (e.is_read) begin
          check("resp_line_o", bus.line_o, e.line);
          last_line = e.line;
        end else begin
          check("write_keeps_line_o", bus.line_o, last_line);
        end
      end
    end
  endtask

  // One cache transaction. pat[c] = resp_i on cycle c (cycle 0 = request).
  task automatic do_txn(input string tag, input logic rd, input logic wr,
                        input addr_t addr, input addr_t exp_addr,
                        input cacheline_t line, input logic [15:0] pat,
                        input int exp_resp_c);
    logic is_w;
    int   beats;
    logic got;
    is_w = wr;
    cyc();
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = is_w ? line : ~line;
    bus.resp_i    = pat[0];
    bus.burst_i   = {$urandom, $urandom};
    resp_q.push_back('{is_read: !is_w, addr: exp_addr, line: line});
    if (is_w) begin
      for (int b = 0; b < BEATS; b++) beat_q.push_back(line[b*BURST_WIDTH +: BURST_WIDTH]);
    end
    beats = 0;
    got   = 1'b0;
    for (int c = 1; c < 16 && !got; c++) begin
      cyc();
      check({tag, "_read_o"},  bus.read_o,  (!is_w && beats < BEATS));
      check({tag, "_write_o"}, bus.write_o, (is_w && beats < BEATS));
      check({tag, "_resp_o"},  bus.resp_o,  (beats == BEATS));
      if (beats < BEATS) check({tag, "_address_o"}, bus.address_o, exp_addr);
      if (bus.resp_o === 1'b1) begin
        got = 1'b1;
        check({tag, "_resp_cycle"}, c, exp_resp_c);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
      end
      bus.resp_i = pat[c];
      if (beats < BEATS && pat[c]) begin
        if (is_w) check({tag, "_burst_o"}, bus.burst_o, beat_q.pop_front());
        else bus.burst_i = line[beats*BURST_WIDTH +: BURST_WIDTH];
        beats++;
      end else begin
        bus.burst_i = {$urandom, $urandom};
      end
    end
    if (!got) check({tag, "_resp_timeout"}, bus.resp_o, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.address_i = 32'h0;
    bus.line_i    = {LINE_WIDTH{1'b0}};
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = 64'h0;
    bus.resp_i    = 1'b0;
    last_line     = {LINE_WIDTH{1'b0}};
    cyc();
    cyc();
    check("rst_read_o",    bus.read_o,    1'b0);
    check("rst_write_o",   bus.write_o,   1'b0);
    check("rst_resp_o",    bus.resp_o,    1'b0);
    check("rst_line_o",    bus.line_o,    {LINE_WIDTH{1'b0}});
    check("rst_burst_o",   bus.burst_o,   64'h0);
    check("rst_address_o", bus.address_o, 32'h0);
    rst = 1'b0;

    // 1: read, beats on cycles 3..6, resp_o on 7
    do_txn("t1", 1'b1, 1'b0, 32'h8000_0047, 32'h8000_0040,
           {64'h0000_0000_0000_000D, 64'h0000_0000_0000_000C,
            64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A},
           16'b0000_0000_0111_1000, 7);

    // 2: write, beats on cycles 2,4,5,9, resp_o on 10
    do_txn("t2", 1'b0, 1'b1, 32'h0000_1000, 32'h0000_1000,
           {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
           16'b0000_0010_0011_0100, 10);

    // 3: both requests raised -> write wins, address aligned
    do_txn("t3", 1'b1, 1'b1, 32'h1234_567F, 32'h1234_5660,
           {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
            64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888},
           16'b0000_0000_0001_1110, 5);

    // 4: reset after two read beats
    cyc();
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_2020;
    bus.resp_i    = 1'b0;
    cyc();
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hDEAD_0000_0000_0001;
    cyc();
    bus.burst_i = 64'hDEAD_0000_0000_0002;
    cyc();
    check("t4_read_o_before_rst", bus.read_o, 1'b1);
    rst         = 1'b1;
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    cyc();
    check("t4_read_o_after_rst",    bus.read_o,    1'b0);
    check("t4_resp_o_after_rst",    bus.resp_o,    1'b0);
    check("t4_line_o_after_rst",    bus.line_o,    {LINE_WIDTH{1'b0}});
    check("t4_address_o_after_rst", bus.address_o, 32'h0);
    rst       = 1'b0;
    last_line = {LINE_WIDTH{1'b0}};
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_no_resp_o", bus.resp_o, 1'b0);
    end
    do_txn("t4b", 1'b1, 1'b0, 32'h0000_2020, 32'h0000_2020,
           {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
            64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001},
           16'b0000_0000_0001_1110, 5);

    // 5: resp_i high through IDLE, the transfer, and DONE
    bus.resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_idle_line_o",  bus.line_o,  last_line);
      check("t5_idle_read_o",  bus.read_o,  1'b0);
      check("t5_idle_write_o", bus.write_o, 1'b0);
      check("t5_idle_resp_o",  bus.resp_o,  1'b0);
    end
    do_txn("t5", 1'b1, 1'b0, 32'h0000_3000, 32'h0000_3000,
           {64'h5A5A_5A5A_0000_0003, 64'h5A5A_5A5A_0000_0002,
            64'h5A5A_5A5A_0000_0001, 64'h5A5A_5A5A_0000_0000},
           16'b0000_0001_1111_1111, 5);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_after_line_o", bus.line_o, last_line);
      check("t5_after_read_o", bus.read_o, 1'b0);
      check("t5_after_resp_o", bus.resp_o, 1'b0);
    end
    bus.resp_i = 1'b0;

    // 6: back-to-back reads, second request raised right after resp_o
    do_txn("t6a", 1'b1, 1'b0, 32'h0000_4000, 32'h0000_4000,
           {64'h6666_0000_0000_00A3, 64'h6666_0000_0000_00A2,
            64'h6666_0000_0000_00A1, 64'h6666_0000_0000_00A0},
           16'b0000_0000_0001_1110, 5);
    do_txn("t6b", 1'b1, 1'b0, 32'h0000_5013, 32'h0000_5000,
           {64'h7777_0000_0000_00B3, 64'h7777_0000_0000_00B2,
            64'h7777_0000_0000_00B1, 64'h7777_0000_0000_00B0},
           16'b0000_0000_0101_0110, 7);

    cyc();
    check("resp_q_drained", resp_q.size(), 0);
    check("beat_q_drained", beat_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
